// File: rtl/givens_row_rotator.sv
// Sequential Givens rotation of rows i/j of a SIZE x SIZE fixed-point matrix, one column per cycle.
// Define GIVENS_ROTATOR_SAT_EN to saturate results and expose sat_flag; otherwise results wrap.
module givens_row_rotator #(
  parameter int unsigned SIZE            = 3,
  parameter int unsigned WORD_LENGTH     = 16,
  parameter int unsigned FRACTION_LENGTH = 12,
  parameter int unsigned IDX_W           = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IDX_W-1:0]                    i_idx,
  input  logic [IDX_W-1:0]                    j_idx,
  input  logic [WORD_LENGTH-1:0]              cos,
  input  logic [WORD_LENGTH-1:0]              sin,
  input  logic [WORD_LENGTH*SIZE*SIZE-1:0]    a_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_LENGTH*SIZE*SIZE-1:0]    a_out,
  output logic                                err
`ifdef GIVENS_ROTATOR_SAT_EN
  ,
  output logic                                sat_flag
`endif
);

  localparam int unsigned W     = WORD_LENGTH;
  localparam int unsigned MW    = W * SIZE * SIZE;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic signed [PW:0] RND = {{PW{1'b0}}, 1'b1} << (FRACTION_LENGTH - 1);
`ifdef GIVENS_ROTATOR_SAT_EN
  localparam logic signed [PW:0] SMAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW:0] SMIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [MW-1:0]         a_q, a_d;
  logic [IDX_W-1:0]      i_q, i_d, j_q, j_d;
  logic signed [W-1:0]   cos_q, cos_d, sin_q, sin_d;
  logic [CNT_W-1:0]      col_q, col_d;
  logic                  err_q, err_d;
`ifdef GIVENS_ROTATOR_SAT_EN
  logic                  sat_q, sat_d;
  logic                  clip_i, clip_j;
`else
  logic                  unused_hi;
`endif

  int unsigned           off_i, off_j;
  logic signed [W-1:0]   ai, aj;
  logic signed [PW-1:0]  ai_x, aj_x, cos_x, sin_x;
  logic signed [PW-1:0]  p_ci, p_sj, p_si, p_cj;
  logic signed [PW:0]    sum_i, sum_j, sh_i, sh_j;
  logic [W-1:0]          new_i, new_j;
  logic                  bad_idx;

  // Single rotation datapath fed from the captured matrix at column col_q.
  always_comb begin
    off_i = (32'(i_q) * SIZE + 32'(col_q)) * W;
    off_j = (32'(j_q) * SIZE + 32'(col_q)) * W;
    ai    = a_q[off_i +: W];
    aj    = a_q[off_j +: W];
    ai_x  = {{W{ai[W-1]}}, ai};
    aj_x  = {{W{aj[W-1]}}, aj};
    cos_x = {{W{cos_q[W-1]}}, cos_q};
    sin_x = {{W{sin_q[W-1]}}, sin_q};
    p_ci  = cos_x * ai_x;
    p_sj  = sin_x * aj_x;
    p_si  = sin_x * ai_x;
    p_cj  = cos_x * aj_x;
    sum_i = {p_ci[PW-1], p_ci} - {p_sj[PW-1], p_sj};
    sum_j = {p_si[PW-1], p_si} + {p_cj[PW-1], p_cj};
    sh_i  = (sum_i + RND) >>> FRACTION_LENGTH;
    sh_j  = (sum_j + RND) >>> FRACTION_LENGTH;
`ifdef GIVENS_ROTATOR_SAT_EN
    clip_i = 1'b0;
    clip_j = 1'b0;
    new_i  = sh_i[W-1:0];
    new_j  = sh_j[W-1:0];
    if (sh_i > SMAX) begin
      new_i  = SMAX[W-1:0];
      clip_i = 1'b1;
    end else if (sh_i < SMIN) begin
      new_i  = SMIN[W-1:0];
      clip_i = 1'b1;
    end
    if (sh_j > SMAX) begin
      new_j  = SMAX[W-1:0];
      clip_j = 1'b1;
    end else if (sh_j < SMIN) begin
      new_j  = SMIN[W-1:0];
      clip_j = 1'b1;
    end
`else
    new_i     = sh_i[W-1:0];
    new_j     = sh_j[W-1:0];
    unused_hi = ^{sh_i[PW:W], sh_j[PW:W]};
`endif
  end

  assign bad_idx = (i_idx == j_idx) || (32'(i_idx) >= SIZE) || (32'(j_idx) >= SIZE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    i_d     = i_q;
    j_d     = j_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    col_d   = col_q;
    err_d   = err_q;
`ifdef GIVENS_ROTATOR_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d   = a_in;
          i_d   = i_idx;
          j_d   = j_idx;
          cos_d = cos;
          sin_d = sin;
          col_d = '0;
`ifdef GIVENS_ROTATOR_SAT_EN
          sat_d = 1'b0;
`endif
          if (bad_idx) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        a_d[off_i +: W] = new_i;
        a_d[off_j +: W] = new_j;
        col_d           = col_q + CNT_W'(1);
`ifdef GIVENS_ROTATOR_SAT_EN
        sat_d           = sat_q | clip_i | clip_j;
`endif
        if (col_q == CNT_W'(SIZE - 1)) begin
          col_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
`ifdef GIVENS_ROTATOR_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      col_q   <= col_d;
      err_q   <= err_d;
`ifdef GIVENS_ROTATOR_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign a_out     = a_q;
  assign err       = err_q;
`ifdef GIVENS_ROTATOR_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: doc/givens_row_rotator.md
Name: givens_row_rotator

Overview:
- Sequential, runtime-configurable Givens rotation engine for the matrix-inversion datapath.
- Accepts a flattened SIZE x SIZE fixed-point matrix A, cos/sin and runtime row indices i, j, and computes Q·A, where Q is the identity except Q[i][i]=cos, Q[i][j]=-sin, Q[j][i]=sin, Q[j][j]=cos.
- Only rows i and j change. They are processed one column per cycle through a single multiply pair.
- Result returned over a valid/ready handshake. Sits between the angle generator and the QR accumulation stage.

Parameters:
SIZE, 3, matrix dimension (>=2)
WORD_LENGTH, 16, signed fixed-point word width
FRACTION_LENGTH, 12, fractional bits (>=1, < WORD_LENGTH)
IDX_W, 2, row-index width; must satisfy 2**IDX_W >= SIZE

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  engine idle, request can be accepted
i_idx  input  IDX_W  first row index
j_idx  input  IDX_W  second row index
cos  input  WORD_LENGTH  signed cos(theta)
sin  input  WORD_LENGTH  signed sin(theta)
a_in  input  WORD_LENGTH*SIZE*SIZE  flattened A; element (m,n) at [(m*SIZE+n)*WORD_LENGTH +: WORD_LENGTH]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
a_out  output  WORD_LENGTH*SIZE*SIZE  flattened Q·A, same packing as a_in
err  output  1  request had invalid indices; qualified by out_valid

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately regardless of state.
  - State IDLE; in_ready=1; out_valid=0; err=0.
  - a_out=0; column counter=0; all captured inputs cleared.
  - Any in-flight request is discarded.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE) only.
- IDLE: on the edge where in_valid && in_ready:
  - Capture a_in into a_out.
  - Capture i_idx, j_idx, cos, sin.
  - Column counter = 0.
  - If i_idx==j_idx, or either index >= SIZE: err=1, go to DONE. a_out is A unchanged; out_valid is high the next cycle.
  - Otherwise: err=0, go to CALC.
- CALC: each edge processes column c = counter.
  - Source values are the captured a_out[i][c] (ai) and a_out[j][c] (aj). Each column is read before its own write, so there are no cross-column hazards.
  - new_i = cos*ai - sin*aj.
  - new_j = sin*ai + cos*aj.
  - Each product is full 2*WORD_LENGTH signed. The sum is 2*WORD_LENGTH+1 bits.
  - Round half-up: add 2**(FRACTION_LENGTH-1), then arithmetic shift right by FRACTION_LENGTH.
  - Reduce to WORD_LENGTH as defined under Optional Feature.
  - Write new_i and new_j to a_out[i][c] and a_out[j][c]; counter increments.
  - After the edge that writes c=SIZE-1: go to DONE, out_valid=1.
  - Latency: out_valid rises SIZE cycles after the acceptance edge.
- DONE: out_valid=1.
  - a_out and err are held stable while out_ready=0, for any number of cycles.
  - On the edge with out_valid && out_ready: out_valid=0, go to IDLE. a_out keeps its last value.
  - in_ready rises the cycle after the handshake. There is no same-cycle turnaround.
- Inputs (a_in, cos, sin, indices) are ignored outside the acceptance edge. They may change freely during CALC/DONE.
- in_valid is ignored whenever in_ready=0; requests are not queued.
- Rows other than i, j are bit-identical to a_in.
- The result is independent of index order only through the sign convention: swapping i and j is equivalent to negating sin.

Optional Feature:
- Macro GIVENS_ROTATOR_SAT_EN.
- Defined: each shifted result is saturated to [-2**(WORD_LENGTH-1), 2**(WORD_LENGTH-1)-1].
  - An extra output sat_flag (1 bit) is exposed.
  - sat_flag is sticky per request: cleared on acceptance, set if any element clipped, valid with out_valid.
- Undefined: the low WORD_LENGTH bits are kept (two's-complement wrap); no sat_flag port.

Test Plan (SIZE=3, WORD_LENGTH=16, FRACTION_LENGTH=12):
1. Identity rotation: cos=0x1000, sin=0, i=0, j=2, A = random values -> out_valid exactly 3 cycles after acceptance; a_out == a_in; err=0.
2. 90-degree rotation: cos=0, sin=0x1000, i=1, j=2, A = identity -> a_out row1 = [0,0,0xF000], row2 = [0,0x1000,0], row0 = [0x1000,0,0].
3. 45-degree rotation: cos=sin=0x0B50, i=0, j=1, every A element 0x1000 -> row0 = 0x0000, row1 = 0x16A0 in all columns; row2 unchanged.
4. Overflow: cos=0x7FFF, sin=0x8001, i=0, j=1, A[0][0]=A[1][0]=0x7FFF -> a_out[0][0] = 0x7FFF with sat_flag=1 when the macro is defined; 0xFFE0 without it.
5. Invalid indices and backpressure: i=j=1 -> out_valid the cycle after acceptance, err=1, a_out == a_in. Then hold out_ready=0 for 5 cycles -> a_out stable, in_ready=0, a second in_valid ignored.
6. Reset mid-CALC: assert rst_n=0 after column 1 -> immediately out_valid=0, in_ready=1, a_out=0. A new request after release completes normally.
